// File: rtl/ppu_pkg.sv
// Shared constants and types for the CPU-side PPU register file and its OAM DMA engine.
package ppu_pkg;

    localparam logic [2:0] REG_CTRL    = 3'd0;
    localparam logic [2:0] REG_MASK    = 3'd1;
    localparam logic [2:0] REG_STATUS  = 3'd2;
    localparam logic [2:0] REG_OAMADDR = 3'd3;
    localparam logic [2:0] REG_OAMDATA = 3'd4;
    localparam logic [2:0] REG_SCROLL  = 3'd5;
    localparam logic [2:0] REG_ADDR    = 3'd6;
    localparam logic [2:0] REG_DATA    = 3'd7;

    typedef enum logic [1:0] {
        DMA_IDLE  = 2'd0,
        DMA_ALIGN = 2'd1,
        DMA_RD    = 2'd2,
        DMA_WR    = 2'd3
    } dma_state_t;

    localparam logic [14:0] INC_ACROSS = 15'd1;
    localparam logic [14:0] INC_DOWN   = 15'd32;
    localparam logic [5:0]  PAL_PAGE   = 6'h3F;

    function automatic logic [14:0] vram_inc(input logic [14:0] addr, input logic down);
        return addr + (down ? INC_DOWN : INC_ACROSS);
    endfunction

endpackage

// File: rtl/ppu_oam_dma.sv
// OAM DMA engine: copies one 256-byte CPU page into OAM while holding the CPU halted.
module ppu_oam_dma
    import ppu_pkg::*;
(
    input  logic        i_cpu_clk,
    input  logic        i_cpu_rstn,
    input  logic        trigger,
    input  logic [7:0]  page_in,
    input  logic [7:0]  dma_rdata,
    output logic        busy,
    output logic        dma_re,
    output logic [15:0] dma_addr,
    output logic        oam_we,
    output logic [7:0]  oam_wdata,
    output logic        oam_inc
);

    dma_state_t state, state_next;
    logic [7:0] page;
    logic [7:0] idx;
    logic       parity;
    logic       extra_align;

    // Parity runs freely; an odd parity at the trigger buys one extra ALIGN cycle.
    always_ff @(posedge i_cpu_clk or negedge i_cpu_rstn) begin
        if (!i_cpu_rstn) begin
            state       <= DMA_IDLE;
            page        <= 8'h00;
            idx         <= 8'h00;
            parity      <= 1'b0;
            extra_align <= 1'b0;
        end else begin
            state  <= state_next;
            parity <= ~parity;
            if (state == DMA_IDLE && trigger) begin
                page        <= page_in;
                idx         <= 8'h00;
                extra_align <= parity;
            end
            if (state == DMA_ALIGN)
                extra_align <= 1'b0;
            if (state == DMA_WR)
                idx <= idx + 8'd1;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b1;
        dma_re     = 1'b0;
        dma_addr   = 16'h0000;
        oam_we     = 1'b0;
        oam_wdata  = dma_rdata;
        oam_inc    = 1'b0;
        case (state)
            DMA_IDLE: begin
                busy = 1'b0;
                if (trigger)
                    state_next = DMA_ALIGN;
            end
            DMA_ALIGN: begin
                if (!extra_align)
                    state_next = DMA_RD;
            end
            DMA_RD: begin
                dma_re     = 1'b1;
                dma_addr   = {page, idx};
                state_next = DMA_WR;
            end
            DMA_WR: begin
                oam_we     = 1'b1;
                oam_inc    = 1'b1;
                state_next = (idx == 8'hFF) ? DMA_IDLE : DMA_RD;
            end
            default: state_next = DMA_IDLE;
        endcase
    end

endmodule

// File: rtl/ppu_regfile.sv
// CPU-facing PPU register file: ctrl/mask/status, scroll and VRAM address state,
// buffered VRAM reads, vblank/NMI and OAM access with optional OAM DMA.
module ppu_regfile
    import ppu_pkg::*;
#(
    parameter int          VRAM_AW = 14,
    parameter int          RD_LAT  = 1,
    parameter bit          DMA_EN  = 1'b1,
    parameter logic [15:0] DMA_REG = 16'h4014
) (
    input  logic               i_cpu_clk,
    input  logic               i_cpu_rstn,
    input  logic               i_bus_en,
    input  logic [15:0]        i_bus_addr,
    input  logic               i_bus_wn,
    input  logic [7:0]         i_bus_wdata,
    output logic [7:0]         o_ppu_rdata,
    output logic               o_cpu_halt,
    output logic [7:0]         o_oam_addr,
    output logic               o_oam_we,
    output logic [7:0]         o_oam_wdata,
    input  logic [7:0]         i_oam_rdata,
    output logic [VRAM_AW-1:0] o_vram_addr,
    output logic               o_vram_we,
    output logic               o_vram_re,
    output logic [7:0]         o_vram_wdata,
    input  logic [7:0]         i_vram_rdata,
    input  logic [7:0]         i_pal_rdata,
    output logic [15:0]        o_dma_addr,
    output logic               o_dma_re,
    input  logic [7:0]         i_dma_rdata,
    input  logic               i_spr_ovfl,
    input  logic               i_spr_0hit,
    input  logic               i_vblank,
    output logic [7:0]         o_ctrl,
    output logic [7:0]         o_mask,
    output logic [14:0]        o_loopy_t,
    output logic [2:0]         o_fine_x,
    output logic               o_nmi_n
);

    logic [7:0]        ctrl, mask, oamaddr, buffer;
    logic [4:0]        lastwrite;
    logic [14:0]       t, v;
    logic [2:0]        fine_x;
    logic              w, vflag, vblank_q;
    logic [RD_LAT-1:0] rd_pipe;

    logic       hit, wr_hit, rd_hit, data_access, status_rd, cpu_oam_we, dma_trigger;
    logic [2:0] reg_idx;
    logic [7:0] d;

    logic        dma_busy, dma_re, dma_oam_we, dma_oam_inc;
    logic [15:0] dma_addr;
    logic [7:0]  dma_oam_wdata;

    assign d           = i_bus_wdata;
    assign reg_idx     = i_bus_addr[2:0];
    assign hit         = i_bus_en && (i_bus_addr[15:13] == 3'b001) && !dma_busy;
    assign wr_hit      = hit && !i_bus_wn;
    assign rd_hit      = hit && i_bus_wn;
    assign data_access = hit && (reg_idx == REG_DATA);
    assign status_rd   = rd_hit && (reg_idx == REG_STATUS);
    assign cpu_oam_we  = wr_hit && (reg_idx == REG_OAMDATA);
    assign dma_trigger = i_bus_en && !i_bus_wn && (i_bus_addr == DMA_REG);

    always_ff @(posedge i_cpu_clk or negedge i_cpu_rstn) begin
        if (!i_cpu_rstn) begin
            ctrl      <= 8'h00;
            mask      <= 8'h00;
            lastwrite <= 5'h00;
            t         <= 15'h0000;
            v         <= 15'h0000;
            fine_x    <= 3'd0;
            w         <= 1'b0;
        end else begin
            if (wr_hit) begin
                lastwrite <= d[4:0];
                case (reg_idx)
                    REG_CTRL: begin
                        ctrl      <= d;
                        t[11:10]  <= d[1:0];
                    end
                    REG_MASK: mask <= d;
                    REG_SCROLL: begin
                        if (!w) begin
                            t[4:0] <= d[7:3];
                            fine_x <= d[2:0];
                        end else begin
                            t[14:12] <= d[2:0];
                            t[9:5]   <= d[7:3];
                        end
                        w <= ~w;
                    end
                    REG_ADDR: begin
                        if (!w) begin
                            t[13:8] <= d[5:0];
                            t[14]   <= 1'b0;
                        end else begin
                            t[7:0] <= d;
                            v      <= {t[14:8], d};
                        end
                        w <= ~w;
                    end
                    default: ;
                endcase
            end
            if (data_access)
                v <= vram_inc(v, ctrl[2]);
            if (status_rd)
                w <= 1'b0;
        end
    end

    // A status read landing on the rising vblank edge wins, suppressing the flag for this frame.
    always_ff @(posedge i_cpu_clk or negedge i_cpu_rstn) begin
        if (!i_cpu_rstn) begin
            vblank_q <= 1'b0;
            vflag    <= 1'b0;
        end else begin
            vblank_q <= i_vblank;
            if (status_rd)
                vflag <= 1'b0;
            else if (i_vblank && !vblank_q)
                vflag <= 1'b1;
            else if (!i_vblank && vblank_q)
                vflag <= 1'b0;
        end
    end

    always_ff @(posedge i_cpu_clk or negedge i_cpu_rstn) begin
        if (!i_cpu_rstn) begin
            rd_pipe <= '0;
            buffer  <= 8'h00;
        end else begin
            rd_pipe[0] <= o_vram_re;
            for (int i = 1; i < RD_LAT; i++)
                rd_pipe[i] <= rd_pipe[i-1];
            if (rd_pipe[RD_LAT-1])
                buffer <= i_vram_rdata;
        end
    end

    always_ff @(posedge i_cpu_clk or negedge i_cpu_rstn) begin
        if (!i_cpu_rstn)
            oamaddr <= 8'h00;
        else if (wr_hit && reg_idx == REG_OAMADDR)
            oamaddr <= d;
        else if (dma_oam_inc || cpu_oam_we)
            oamaddr <= oamaddr + 8'd1;
    end

    always_comb begin
        o_ppu_rdata = 8'h00;
        if (rd_hit) begin
            case (reg_idx)
                REG_STATUS:  o_ppu_rdata = {vflag, i_spr_0hit, i_spr_ovfl, lastwrite};
                REG_OAMDATA: o_ppu_rdata = i_oam_rdata;
                REG_DATA:    o_ppu_rdata = (v[13:8] == PAL_PAGE) ? i_pal_rdata : buffer;
                default:     o_ppu_rdata = 8'h00;
            endcase
        end
    end

    generate
        if (DMA_EN) begin : g_dma
            ppu_oam_dma u_dma (
                .i_cpu_clk  (i_cpu_clk),
                .i_cpu_rstn (i_cpu_rstn),
                .trigger    (dma_trigger),
                .page_in    (i_bus_wdata),
                .dma_rdata  (i_dma_rdata),
                .busy       (dma_busy),
                .dma_re     (dma_re),
                .dma_addr   (dma_addr),
                .oam_we     (dma_oam_we),
                .oam_wdata  (dma_oam_wdata),
                .oam_inc    (dma_oam_inc)
            );
        end else begin : g_no_dma
            assign dma_busy      = 1'b0;
            assign dma_re        = 1'b0;
            assign dma_addr      = 16'h0000;
            assign dma_oam_we    = 1'b0;
            assign dma_oam_wdata = 8'h00;
            assign dma_oam_inc   = 1'b0;
        end
    endgenerate

    assign o_cpu_halt   = dma_busy;
    assign o_dma_re     = dma_re;
    assign o_dma_addr   = dma_addr;
    assign o_oam_addr   = oamaddr;
    assign o_oam_we     = dma_oam_we || cpu_oam_we;
    assign o_oam_wdata  = dma_oam_we ? dma_oam_wdata : d;
    assign o_vram_addr  = v[VRAM_AW-1:0];
    assign o_vram_we    = wr_hit && (reg_idx == REG_DATA);
    assign o_vram_re    = rd_hit && (reg_idx == REG_DATA);
    assign o_vram_wdata = d;
    assign o_ctrl       = ctrl;
    assign o_mask       = mask;
    assign o_loopy_t    = t;
    assign o_fine_x     = fine_x;
    assign o_nmi_n      = ~(vflag & ctrl[7]);

endmodule

// File: tb/tb_ppu_regfile.sv
// Directed self-checking bench for ppu_regfile with simple VRAM, palette, OAM and CPU-memory models.
module tb_ppu_regfile;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        bus_en = 1'b0;
    logic [15:0] bus_addr = 16'h0000;
    logic        bus_wn = 1'b1;
    logic [7:0]  bus_wdata = 8'h00;
    logic [7:0]  ppu_rdata;
    logic        cpu_halt;
    logic [7:0]  oam_addr, oam_wdata, oam_rdata;
    logic        oam_we;
    logic [13:0] vram_addr;
    logic        vram_we, vram_re;
    logic [7:0]  vram_wdata, vram_q, pal_rdata;
    logic [15:0] dma_addr;
    logic        dma_re;
    logic [7:0]  dma_q;
    logic        spr_ovfl = 1'b0, spr_0hit = 1'b0, vblank = 1'b0;
    logic [7:0]  ctrl, mask;
    logic [14:0] loopy_t;
    logic [2:0]  fine_x;
    logic        nmi_n;

    logic [7:0]  vram [0:16383];
    logic [7:0]  pal  [0:31];
    logic [7:0]  oam  [0:255];
    int          cyc;
    int          total = 0;
    int          bad = 0;
    logic [7:0]  rd;

    always #5 clk = ~clk;

    ppu_regfile #(.VRAM_AW(14), .RD_LAT(1), .DMA_EN(1'b1), .DMA_REG(16'h4014)) dut (
        .i_cpu_clk    (clk),
        .i_cpu_rstn   (rstn),
        .i_bus_en     (bus_en),
        .i_bus_addr   (bus_addr),
        .i_bus_wn     (bus_wn),
        .i_bus_wdata  (bus_wdata),
        .o_ppu_rdata  (ppu_rdata),
        .o_cpu_halt   (cpu_halt),
        .o_oam_addr   (oam_addr),
        .o_oam_we     (oam_we),
        .o_oam_wdata  (oam_wdata),
        .i_oam_rdata  (oam_rdata),
        .o_vram_addr  (vram_addr),
        .o_vram_we    (vram_we),
        .o_vram_re    (vram_re),
        .o_vram_wdata (vram_wdata),
        .i_vram_rdata (vram_q),
        .i_pal_rdata  (pal_rdata),
        .o_dma_addr   (dma_addr),
        .o_dma_re     (dma_re),
        .i_dma_rdata  (dma_q),
        .i_spr_ovfl   (spr_ovfl),
        .i_spr_0hit   (spr_0hit),
        .i_vblank     (vblank),
        .o_ctrl       (ctrl),
        .o_mask       (mask),
        .o_loopy_t    (loopy_t),
        .o_fine_x     (fine_x),
        .o_nmi_n      (nmi_n)
    );

    // The VRAM model mirrors $3000-$3FFF onto $2000-$2FFF, as nametable RAM does under the palette.
    function automatic logic [13:0] vram_map(input logic [13:0] a);
        return (a[13:12] == 2'b11) ? (a - 14'h1000) : a;
    endfunction

    function automatic logic [7:0] dma_src(input logic [15:0] a);
        return (a[7:0] ^ 8'hC3) + a[15:8];
    endfunction

    always @(posedge clk) begin
        if (vram_re) vram_q <= vram[vram_map(vram_addr)];
        if (vram_we) vram[vram_map(vram_addr)] <= vram_wdata;
        if (oam_we)  oam[oam_addr] <= oam_wdata;
        if (dma_re)  dma_q <= dma_src(dma_addr);
    end

    assign pal_rdata = pal[vram_addr[4:0]];
    assign oam_rdata = oam[oam_addr];

    always @(posedge clk or negedge rstn) begin
        if (!rstn) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] addr, input logic wn, input logic [7:0] wdata,
                                 output logic [7:0] rdata);
        @(negedge clk);
        bus_en = 1'b1; bus_addr = addr; bus_wn = wn; bus_wdata = wdata;
        #1 rdata = ppu_rdata;
        @(negedge clk);
        bus_en = 1'b0; bus_wn = 1'b1;
    endtask

    task automatic ppu_write(input logic [15:0] addr, input logic [7:0] wdata);
        logic [7:0] dummy;
        applyStimulus(addr, 1'b0, wdata, dummy);
    endtask

    task automatic ppu_read(input logic [15:0] addr, output logic [7:0] rdata);
        applyStimulus(addr, 1'b1, 8'h00, rdata);
    endtask

    // Triggers a DMA on a cycle of the requested parity; optionally pokes the bus while halted.
    task automatic run_dma(input logic [7:0] page, input logic want_par, input logic inject);
        int len, errs;
        logic par;
        @(negedge clk);
        if (cyc[0] != want_par) @(negedge clk);
        par = cyc[0];
        bus_en = 1'b1; bus_addr = 16'h4014; bus_wn = 1'b0; bus_wdata = page;
        @(negedge clk);
        bus_en = 1'b0; bus_wn = 1'b1;
        len = 0;
        while (cpu_halt && len < 1000) begin
            len++;
            if (inject && len == 50) begin
                bus_en = 1'b1; bus_addr = 16'h4014; bus_wn = 1'b0; bus_wdata = 8'h05;
            end else if (inject && len == 51) begin
                bus_addr = 16'h2000; bus_wdata = 8'h55;
            end else if (inject && len == 52) begin
                bus_en = 1'b0; bus_wn = 1'b1;
            end
            @(negedge clk);
        end
        checkOutput("dma_len", len, par ? 514 : 513);
        errs = 0;
        for (int i = 0; i < 256; i++) begin
            logic [7:0] slot;
            slot = 8'h10 + 8'(i);
            if (oam[slot] !== dma_src({page, 8'(i)})) errs++;
        end
        checkOutput("dma_data", errs, 0);
        checkOutput("dma_oamaddr", oam_addr, 8'h10);
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) vram[i] = 8'h00;
        for (int i = 0; i < 32; i++) pal[i] = 8'h00;
        for (int i = 0; i < 256; i++) oam[i] = 8'h00;
        vram_q = 8'h00;
        dma_q  = 8'h00;

        #2 rstn = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_nmi_n", nmi_n, 1'b1);
        checkOutput("rst_halt", cpu_halt, 1'b0);
        checkOutput("rst_ctrl", ctrl, 8'h00);
        checkOutput("rst_t", loopy_t, 15'h0000);
        rstn = 1'b1;

        ppu_write(16'h2001, 8'h1E);
        checkOutput("mask", mask, 8'h1E);
        ppu_write(16'h2000, 8'h03);
        checkOutput("ctrl_t_nt", loopy_t, 15'h0C00);
        ppu_write(16'h2000, 8'h00);

        ppu_write(16'h2005, 8'h7D);
        ppu_write(16'h2005, 8'h5E);
        checkOutput("scroll_t", loopy_t, 15'h616F);
        checkOutput("scroll_x", fine_x, 3'd5);

        vram[14'h2108] = 8'hAA; vram[14'h2109] = 8'hBB;
        vram[14'h210A] = 8'hCC; vram[14'h210B] = 8'h33;
        ppu_write(16'h2006, 8'h21);
        checkOutput("addr_t_hi", loopy_t, 15'h216F);
        ppu_write(16'h2006, 8'h08);
        checkOutput("addr_v", vram_addr, 14'h2108);
        ppu_read(16'h2007, rd); checkOutput("rd1_stale", rd, 8'h00);
        ppu_read(16'h2007, rd); checkOutput("rd2", rd, 8'hAA);
        ppu_read(16'h2007, rd); checkOutput("rd3", rd, 8'hBB);
        checkOutput("v_inc1", vram_addr, 14'h210B);
        ppu_write(16'h2000, 8'h04);
        ppu_read(16'h2007, rd); checkOutput("rd4", rd, 8'hCC);
        checkOutput("v_inc32a", vram_addr, 14'h212B);
        ppu_read(16'h2007, rd); checkOutput("rd5", rd, 8'h33);
        checkOutput("v_inc32b", vram_addr, 14'h214B);
        ppu_write(16'h2007, 8'h5A);
        checkOutput("vram_wr", vram[14'h214B], 8'h5A);
        checkOutput("v_inc32c", vram_addr, 14'h216B);

        ppu_write(16'h2000, 8'h00);
        pal[1] = 8'h16; vram[14'h2F01] = 8'h44;
        ppu_write(16'h2006, 8'h3F);
        ppu_write(16'h2006, 8'h01);
        ppu_read(16'h2007, rd); checkOutput("pal_rd", rd, 8'h16);
        ppu_write(16'h2006, 8'h21);
        ppu_write(16'h2006, 8'h00);
        ppu_read(16'h2007, rd); checkOutput("pal_buffer", rd, 8'h44);

        ppu_write(16'h2003, 8'h10);
        ppu_write(16'h2004, 8'hAB);
        checkOutput("oam_wr", oam[8'h10], 8'hAB);
        checkOutput("oam_inc", oam_addr, 8'h11);
        ppu_write(16'h2003, 8'h10);
        ppu_read(16'h2004, rd); checkOutput("oam_rd", rd, 8'hAB);
        checkOutput("oam_noinc", oam_addr, 8'h10);
        ppu_read(16'h2001, rd); checkOutput("mask_rd0", rd, 8'h00);
        ppu_read(16'h2005, rd); checkOutput("scroll_rd0", rd, 8'h00);
        spr_0hit = 1'b1; spr_ovfl = 1'b1;
        ppu_read(16'h2002, rd); checkOutput("status", rd, 8'h70);
        spr_0hit = 1'b0; spr_ovfl = 1'b0;

        ppu_write(16'h2000, 8'h80);
        ppu_write(16'h2005, 8'h00);
        @(negedge clk); vblank = 1'b1;
        @(negedge clk);
        checkOutput("nmi_assert", nmi_n, 1'b0);
        ppu_read(16'h2002, rd); checkOutput("status_vbl", rd, 8'h80);
        checkOutput("nmi_clear", nmi_n, 1'b1);
        ppu_write(16'h2006, 8'h15);
        ppu_write(16'h2006, 8'h00);
        checkOutput("w_cleared", vram_addr, 14'h1500);
        @(negedge clk); vblank = 1'b0;
        repeat (2) @(negedge clk);

        vblank = 1'b1; bus_en = 1'b1; bus_addr = 16'h2002; bus_wn = 1'b1;
        #1 rd = ppu_rdata;
        checkOutput("supp_bit7", rd[7], 1'b0);
        @(negedge clk); bus_en = 1'b0;
        checkOutput("supp_nmi_a", nmi_n, 1'b1);
        repeat (2) @(negedge clk);
        checkOutput("supp_nmi_b", nmi_n, 1'b1);
        vblank = 1'b0;
        repeat (2) @(negedge clk);

        ppu_write(16'h2000, 8'h00);
        vblank = 1'b1;
        @(negedge clk);
        checkOutput("nmi_masked", nmi_n, 1'b1);
        ppu_write(16'h2000, 8'h80);
        checkOutput("nmi_late_en", nmi_n, 1'b0);
        ppu_read(16'h2002, rd); checkOutput("status_vbl2", rd, 8'h80);
        vblank = 1'b0;
        repeat (2) @(negedge clk);

        ppu_write(16'h2003, 8'h10);
        run_dma(8'h02, 1'b0, 1'b0);
        run_dma(8'h03, 1'b1, 1'b1);
        checkOutput("halt_ignores_ctrl", ctrl, 8'h80);

        @(negedge clk); vblank = 1'b1;
        ppu_write(16'h4014, 8'h04);
        repeat (99) @(negedge clk);
        checkOutput("mid_halt", cpu_halt, 1'b1);
        checkOutput("mid_nmi", nmi_n, 1'b0);
        rstn = 1'b0;
        #1;
        checkOutput("mrst_halt", cpu_halt, 1'b0);
        checkOutput("mrst_nmi_n", nmi_n, 1'b1);
        checkOutput("mrst_ctrl", ctrl, 8'h00);
        checkOutput("mrst_mask", mask, 8'h00);
        checkOutput("mrst_t", loopy_t, 15'h0000);
        checkOutput("mrst_x", fine_x, 3'd0);
        checkOutput("mrst_oamaddr", oam_addr, 8'h00);
        checkOutput("mrst_v", vram_addr, 14'h0000);
        checkOutput("mrst_dma_re", dma_re, 1'b0);
        checkOutput("mrst_oam_we", oam_we, 1'b0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        vblank = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("post_rst_halt", cpu_halt, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
